uart_triangle_loader: RTL

Byte-stream parser sitting directly downstream of the board UART receiver in the bootloader path. It consumes received bytes, decodes a load command header, and assembles each 18-byte payload into one triangle (3 vertices × x,y,z, 16-bit each). It presents each triangle to the triangle store over a valid/ready handshake, with `tri_last` marking the final triangle of a command.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/tri_out_reg.sv | 64 ++++++
 rtl/uart_triangle_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART triangle loader.
// Structs describe the 144-bit triangle layout at the default 16-bit coordinate width.
package loader_pkg;

    localparam logic [7:0] CMD_LOAD_DEFAULT = 8'h01;
    localparam int         COORD_W_DEFAULT  = 16;
    localparam int         TRI_BYTES        = 9 * COORD_W_DEFAULT / 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4
    } loader_state_t;

    // First member is the MSB, so x sits in the low bits of each vertex.
    typedef struct packed {
        logic [COORD_W_DEFAULT-1:0] z;
        logic [COORD_W_DEFAULT-1:0] y;
        logic [COORD_W_DEFAULT-1:0] x;
    } vertex_t;

    typedef struct packed {
        vertex_t v2;
        vertex_t v1;
        vertex_t v0;
    } triangle_t;

endpackage

// File: rtl/tri_out_reg.sv
// Output holding register for assembled triangles with valid/ready handshake.
// Reloads on the same edge the held triangle drains, so there is no bubble.
module tri_out_reg #(
    parameter int W = 144
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic [15:0]  load_index_i,
    input  logic         load_last_i,
    output logic         can_load_o,
    input  logic         tri_ready,
    output logic         tri_valid,
    output logic [W-1:0] tri_data,
    output logic [15:0]  tri_index,
    output logic         tri_last
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic [15:0]  index_q, index_d;
    logic         last_q,  last_d;

    assign can_load_o = !valid_q || tri_ready;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        if (load_i && can_load_o) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
            index_d = load_index_i;
            last_d  = load_last_i;
        end else if (tri_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data register is reset too because its reset value is visible on the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
        end
    end

    assign tri_valid = valid_q;
    assign tri_data  = data_q;
    assign tri_index = index_q;
    assign tri_last  = last_q;

endmodule

// File: rtl/uart_triangle_loader.sv
// UART byte-stream parser: CMD_LOAD, 16-bit count (N-1), then N triangle payloads.
// Optional per-triangle XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_triangle_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] CMD_LOAD = CMD_LOAD_DEFAULT,
    parameter int         COORD_W  = COORD_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_rdy,
    output logic                 clr_rx_rdy,
    output logic [9*COORD_W-1:0] tri_data,
    output logic                 tri_valid,
    input  logic                 tri_ready,
    output logic                 tri_last,
    output logic [15:0]          tri_index,
    output logic                 busy,
    output logic                 err_cmd,
    output logic                 err_chk
);

    localparam int         DATA_W    = 9 * COORD_W;
    localparam int         TRI_B     = DATA_W / 8;
    localparam logic [7:0] BYTE_LAST = 8'(TRI_B - 1);

    loader_state_t     state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       tri_cnt_q, tri_cnt_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              err_cmd_q, err_cmd_d;
    logic              clr_q;
    logic              load;
    logic              can_load;
    logic              completes;
    logic              take;
    logic              is_last;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;
    logic       err_chk_q, err_chk_d;
    assign completes = (state_q == ST_CHK);
`else
    assign completes = (state_q == ST_DATA) && (byte_cnt_q == BYTE_LAST);
`endif

    // The cycle after a consume, rx_rdy is still the stale level of the old byte.
    assign take       = !rst && rx_rdy && !clr_q && !(completes && !can_load);
    assign clr_rx_rdy = take;
    assign is_last    = (tri_cnt_q == count_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tri_cnt_d  = tri_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        err_cmd_d  = err_cmd_q;
        load       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q;
        err_chk_d  = err_chk_q;
`endif
        if (take) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == CMD_LOAD) state_d = ST_CNT_LO;
                    else                     err_cmd_d = 1'b1;
                end
                ST_CNT_LO: begin
                    count_d[7:0] = rx_data;
                    tri_cnt_d    = '0;
                    state_d      = ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    count_d[15:8] = rx_data;
                    tri_cnt_d     = '0;
                    byte_cnt_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d         = '0;
`endif
                    state_d       = ST_DATA;
                end
                ST_DATA: begin
                    for (int k = 0; k < TRI_B; k++) begin
                        if (byte_cnt_q == 8'(k)) asm_d[8*k +: 8] = rx_data;
                    end
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ rx_data;
`endif
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                        state_d    = ST_CHK;
`else
                        load       = 1'b1;
                        tri_cnt_d  = tri_cnt_q + 16'd1;
                        state_d    = is_last ? ST_IDLE : ST_DATA;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    // A bad triangle still consumes its slot so the frame stays aligned.
                    if (rx_data == chk_q) load = 1'b1;
                    else                  err_chk_d = 1'b1;
                    chk_d     = '0;
                    tri_cnt_d = tri_cnt_q + 16'd1;
                    state_d   = is_last ? ST_IDLE : ST_DATA;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tri_cnt_q  <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            err_cmd_q  <= 1'b0;
            clr_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
            err_chk_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tri_cnt_q  <= tri_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            err_cmd_q  <= err_cmd_d;
            clr_q      <= take;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
            err_chk_q  <= err_chk_d;
`endif
        end
    end

    tri_out_reg #(.W(DATA_W)) u_out (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .load_data_i  (asm_d),
        .load_index_i (tri_cnt_q),
        .load_last_i  (is_last),
        .can_load_o   (can_load),
        .tri_ready    (tri_ready),
        .tri_valid    (tri_valid),
        .tri_data     (tri_data),
        .tri_index    (tri_index),
        .tri_last     (tri_last)
    );

    assign busy    = (state_q != ST_IDLE);
    assign err_cmd = err_cmd_q;
`ifdef LOADER_CHECKSUM_EN
    assign err_chk = err_chk_q;
`else
    assign err_chk = 1'b0;
`endif

endmodule
